dmem_load_store_fsm: RTL and testbench

Data-memory port sequencer between the load reservation station / store buffer and the data cache. Each cycle in IDLE it arbitrates between the load RS's pending read request and the store buffer head's write request. It holds the winning request on the single dcache port until the response arrives. It returns load data with the RS slot index, or pops the committed store. A pipeline flush discards an in-flight load's response; a committed store always runs to completion.

---
 rtl/dmem_load_store_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_dmem_load_store_fsm.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_load_store_fsm.sv
// -----------------------------------------------------------------------------
// dmem_load_store_fsm
//
// Purpose:
//   Sequences the single data-cache port between the load reservation station
//   and the store buffer head. In IDLE it picks one requester, registers that
//   request onto the cache port and holds it until dcache_resp. Load responses
//   go back to the RS with the slot index. Store completions pop the store
//   buffer. A pipeline flush discards an in-flight load's response. A committed
//   store always runs to completion.
//
// Optional feature:
//   STORE_STARVE_GUARD_EN - when defined, a 4-bit counter tracks IDLE cycles in
//   which a waiting store lost to a load. When it reaches STARVE_LIMIT, the
//   store is granted regardless of dmem_r_rqst. When undefined, loads have
//   priority unless the store buffer is full.
//
// Parameters:
//   LOAD_RS_DEPTH  log2 of load RS entries (width of the slot index)
//   STARVE_LIMIT   denied-store cycles before a forced store grant
//                  (present only when STORE_STARVE_GUARD_EN is defined)
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   move_flush                  pipeline flush pulse
//   dmem_r_rqst                 load RS has an issuable load
//   load_rs_dmem_idx_rqst       RS slot of that load
//   arbiter_load_rs_addr/rmask  load byte address / byte mask
//   load_rs_dmem_ready          load response pulse (combinational in resp cycle)
//   load_rs_dmem_idx_executing  slot of the completing load (0 otherwise)
//   dmem_rdata                  raw cache word for the load (0 otherwise)
//   store_buffer_w_rqst         store buffer head valid
//   store_buffer_full           store buffer has no free entry
//   store_buffer_head_*         head store address / byte mask / data
//   store_buffer_pop            head store written, dequeue (resp cycle)
//   dcache_addr                 registered word-aligned address
//   dcache_rmask/wmask/wdata    registered read mask / write mask / write data
//   dcache_resp/rdata           cache completion pulse / read word
// -----------------------------------------------------------------------------
module dmem_load_store_fsm #(
  parameter int LOAD_RS_DEPTH = 3
`ifdef STORE_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     move_flush,
  // load reservation station side
  input  logic                     dmem_r_rqst,
  input  logic [LOAD_RS_DEPTH-1:0] load_rs_dmem_idx_rqst,
  input  logic [31:0]              arbiter_load_rs_addr,
  input  logic [3:0]               arbiter_load_rs_rmask,
  output logic                     load_rs_dmem_ready,
  output logic [LOAD_RS_DEPTH-1:0] load_rs_dmem_idx_executing,
  output logic [31:0]              dmem_rdata,
  // store buffer side
  input  logic                     store_buffer_w_rqst,
  input  logic                     store_buffer_full,
  input  logic [31:0]              store_buffer_head_addr,
  input  logic [3:0]               store_buffer_head_wmask,
  input  logic [31:0]              store_buffer_head_wdata,
  output logic                     store_buffer_pop,
  // data cache side
  output logic [31:0]              dcache_addr,
  output logic [3:0]               dcache_rmask,
  output logic [3:0]               dcache_wmask,
  output logic [31:0]              dcache_wdata,
  input  logic                     dcache_resp,
  input  logic [31:0]              dcache_rdata
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOAD_WAIT  = 2'd1,
    S_STORE_WAIT = 2'd2,
    S_LOAD_DRAIN = 2'd3  // flushed load still owns the port; response is dropped
  } state_t;

  state_t                   r_state;
  logic [31:0]              r_addr;
  logic [3:0]               r_rmask;
  logic [3:0]               r_wmask;
  logic [31:0]              r_wdata;
  logic [LOAD_RS_DEPTH-1:0] r_idx;

  logic w_starved;
  logic w_store_win;
  logic w_load_win;
  logic w_load_done;
  logic w_store_done;

  // ---------------------------------------------------------------------------
  // Store starvation guard
  // ---------------------------------------------------------------------------
`ifdef STORE_STARVE_GUARD_EN
  logic [3:0] r_starve_cnt;

  assign w_starved = (r_starve_cnt >= 4'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (r_state == S_IDLE) begin
      if (w_store_win) begin
        r_starve_cnt <= 4'd0;
      end else if (w_load_win && store_buffer_w_rqst && (r_starve_cnt != 4'hF)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end
`else
  assign w_starved = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // IDLE arbitration. A full store buffer (or a starved store) beats a load.
  // A flush blocks only a new load; a committed store is still granted.
  // ---------------------------------------------------------------------------
  // NOTE: continuous assigns for pure combinational terms cannot infer latches;
  // every output below is defined for all input combinations.
  assign w_store_win = store_buffer_w_rqst &&
                       (store_buffer_full || !dmem_r_rqst || w_starved);
  assign w_load_win  = !w_store_win && dmem_r_rqst && !move_flush;

  // Completion terms. A flush coinciding with the response kills the pulse.
  assign w_load_done  = (r_state == S_LOAD_WAIT) && dcache_resp && !move_flush;
  assign w_store_done = (r_state == S_STORE_WAIT) && dcache_resp;

  // Response-side outputs are zero in every cycle without a ready pulse.
  assign load_rs_dmem_ready         = w_load_done;
  assign load_rs_dmem_idx_executing = w_load_done ? r_idx : '0;
  assign dmem_rdata                 = w_load_done ? dcache_rdata : 32'd0;
  assign store_buffer_pop           = w_store_done;

  assign dcache_addr  = r_addr;
  assign dcache_rmask = r_rmask;
  assign dcache_wmask = r_wmask;
  assign dcache_wdata = r_wdata;

  // ---------------------------------------------------------------------------
  // Port sequencer: state plus the registered cache request.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is a plain flop, so all are cleared by the
    // asynchronous reset; an abandoned cache access leaves nothing behind.
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= 32'd0;
      r_rmask <= 4'd0;
      r_wmask <= 4'd0;
      r_wdata <= 32'd0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_store_win) begin
            r_state <= S_STORE_WAIT;
            r_addr  <= store_buffer_head_addr & ~32'h3;
            r_wmask <= store_buffer_head_wmask;
            r_wdata <= store_buffer_head_wdata;
            r_rmask <= 4'd0;
          end else if (w_load_win) begin
            r_state <= S_LOAD_WAIT;
            r_addr  <= arbiter_load_rs_addr & ~32'h3;
            r_rmask <= arbiter_load_rs_rmask;
            r_idx   <= load_rs_dmem_idx_rqst;
            r_wmask <= 4'd0;
            r_wdata <= 32'd0;
          end
        end

        S_LOAD_WAIT: begin
          if (dcache_resp) begin
            r_state <= S_IDLE;
            r_addr  <= 32'd0;
            r_rmask <= 4'd0;
            r_idx   <= '0;
          end else if (move_flush) begin
            // Request stays on the port; only the response is discarded.
            r_state <= S_LOAD_DRAIN;
          end
        end

        S_LOAD_DRAIN: begin
          if (dcache_resp) begin
            r_state <= S_IDLE;
            r_addr  <= 32'd0;
            r_rmask <= 4'd0;
            r_idx   <= '0;
          end
        end

        S_STORE_WAIT: begin
          if (dcache_resp) begin
            r_state <= S_IDLE;
            r_addr  <= 32'd0;
            r_wmask <= 4'd0;
            r_wdata <= 32'd0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_load_store_fsm.sv
// -----------------------------------------------------------------------------
// tb_dmem_load_store_fsm
//
// Self-checking bench for dmem_load_store_fsm. Transactions are described as
// records (requests presented in IDLE, response latency, optional flush cycle)
// and expected behaviour is derived from the arbitration and completion rules.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_dmem_load_store_fsm;

  localparam int IDXW            = 3;
  localparam int TB_STARVE_LIMIT = 8;
`ifdef STORE_STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  localparam int G_NONE  = 0;
  localparam int G_LOAD  = 1;
  localparam int G_STORE = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            move_flush;
  logic            dmem_r_rqst;
  logic [IDXW-1:0] load_rs_dmem_idx_rqst;
  logic [31:0]     arbiter_load_rs_addr;
  logic [3:0]      arbiter_load_rs_rmask;
  logic            load_rs_dmem_ready;
  logic [IDXW-1:0] load_rs_dmem_idx_executing;
  logic [31:0]     dmem_rdata;
  logic            store_buffer_w_rqst;
  logic            store_buffer_full;
  logic [31:0]     store_buffer_head_addr;
  logic [3:0]      store_buffer_head_wmask;
  logic [31:0]     store_buffer_head_wdata;
  logic            store_buffer_pop;
  logic [31:0]     dcache_addr;
  logic [3:0]      dcache_rmask;
  logic [3:0]      dcache_wmask;
  logic [31:0]     dcache_wdata;
  logic            dcache_resp;
  logic [31:0]     dcache_rdata;

  dmem_load_store_fsm #(.LOAD_RS_DEPTH(IDXW)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .move_flush                 (move_flush),
    .dmem_r_rqst                (dmem_r_rqst),
    .load_rs_dmem_idx_rqst      (load_rs_dmem_idx_rqst),
    .arbiter_load_rs_addr       (arbiter_load_rs_addr),
    .arbiter_load_rs_rmask      (arbiter_load_rs_rmask),
    .load_rs_dmem_ready         (load_rs_dmem_ready),
    .load_rs_dmem_idx_executing (load_rs_dmem_idx_executing),
    .dmem_rdata                 (dmem_rdata),
    .store_buffer_w_rqst        (store_buffer_w_rqst),
    .store_buffer_full          (store_buffer_full),
    .store_buffer_head_addr     (store_buffer_head_addr),
    .store_buffer_head_wmask    (store_buffer_head_wmask),
    .store_buffer_head_wdata    (store_buffer_head_wdata),
    .store_buffer_pop           (store_buffer_pop),
    .dcache_addr                (dcache_addr),
    .dcache_rmask               (dcache_rmask),
    .dcache_wmask               (dcache_wmask),
    .dcache_wdata               (dcache_wdata),
    .dcache_resp                (dcache_resp),
    .dcache_rdata               (dcache_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          ld;
    bit          st;
    bit          full;
    bit          fl_idle;   // flush asserted in the arbitration cycle
    logic [2:0]  idx;
    logic [31:0] laddr;
    logic [3:0]  rmask;
    logic [31:0] saddr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;       // resp arrives this many cycles after the grant
    int          flush_at;  // wait-cycle offset of a flush pulse, -1 = none
    int          exp_grant;
  } txn_t;

  int n_checks = 0;
  int n_pass   = 0;
  int starve   = 0;  // consecutive arbitrations a waiting store has lost

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic txn_t mk(input string name, input bit ld, input bit st,
                              input bit full, input bit fl_idle,
                              input logic [2:0] idx, input logic [31:0] laddr,
                              input logic [3:0] rmask, input logic [31:0] saddr,
                              input logic [3:0] wmask, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int lat,
                              input int flush_at, input int exp_grant);
    txn_t t;
    t.name = name; t.ld = ld; t.st = st; t.full = full; t.fl_idle = fl_idle;
    t.idx = idx; t.laddr = laddr; t.rmask = rmask; t.saddr = saddr;
    t.wmask = wmask; t.wdata = wdata; t.rdata = rdata; t.lat = lat;
    t.flush_at = flush_at; t.exp_grant = exp_grant;
    return t;
  endfunction

  // Arbitration rule: who owns the port after this IDLE cycle.
  function automatic int model_grant(input txn_t t);
    bit starved;
    starved = GUARD_EN && (starve >= TB_STARVE_LIMIT);
    if (t.st && (t.full || !t.ld || starved)) return G_STORE;
    if (t.ld && !t.fl_idle) return G_LOAD;
    return G_NONE;
  endfunction

  task automatic idle_inputs();
    move_flush = 1'b0; dmem_r_rqst = 1'b0; load_rs_dmem_idx_rqst = '0;
    arbiter_load_rs_addr = '0; arbiter_load_rs_rmask = '0;
    store_buffer_w_rqst = 1'b0; store_buffer_full = 1'b0;
    store_buffer_head_addr = '0; store_buffer_head_wmask = '0;
    store_buffer_head_wdata = '0; dcache_resp = 1'b0; dcache_rdata = '0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    starve = 0;
  endtask

  // One arbitration cycle followed by the full lifetime of the granted access.
  task automatic do_txn(input txn_t t, input int g, output int seen);
    bit flushed;
    bit fl;
    bit exp_rdy;
    flushed = 1'b0;
    seen = G_NONE;
    @(negedge clk);
    dmem_r_rqst = t.ld; load_rs_dmem_idx_rqst = t.idx;
    arbiter_load_rs_addr = t.laddr; arbiter_load_rs_rmask = t.rmask;
    store_buffer_w_rqst = t.st; store_buffer_full = t.full;
    store_buffer_head_addr = t.saddr; store_buffer_head_wmask = t.wmask;
    store_buffer_head_wdata = t.wdata; move_flush = t.fl_idle;
    dcache_resp = 1'b0; dcache_rdata = t.rdata;
    #1;
    check($sformatf("%s/idle_rmask", t.name), 32'(dcache_rmask), 32'd0);
    check($sformatf("%s/idle_wmask", t.name), 32'(dcache_wmask), 32'd0);

    if (g == G_STORE) starve = 0;
    else if (g == G_LOAD && t.st) starve++;

    if (g == G_NONE) begin
      @(negedge clk);
      idle_inputs();
      #1;
      check($sformatf("%s/nogrant_rmask", t.name), 32'(dcache_rmask), 32'd0);
      check($sformatf("%s/nogrant_wmask", t.name), 32'(dcache_wmask), 32'd0);
      return;
    end

    for (int c = 1; c <= t.lat; c++) begin
      @(negedge clk);
      dmem_r_rqst = 1'b0; store_buffer_w_rqst = 1'b0; store_buffer_full = 1'b0;
      fl = (c == t.flush_at);
      move_flush  = fl;
      dcache_resp = (c == t.lat);
      dcache_rdata = t.rdata;
      #1;
      if (c == 1) seen = (dcache_wmask != 0) ? G_STORE : (dcache_rmask != 0) ? G_LOAD : G_NONE;
      if (g == G_LOAD) begin
        exp_rdy = (c == t.lat) && !flushed && !fl;
        check($sformatf("%s/c%0d/addr", t.name, c), dcache_addr, t.laddr & ~32'h3);
        check($sformatf("%s/c%0d/rmask", t.name, c), 32'(dcache_rmask), 32'(t.rmask));
        check($sformatf("%s/c%0d/wmask", t.name, c), 32'(dcache_wmask), 32'd0);
        check($sformatf("%s/c%0d/ready", t.name, c), 32'(load_rs_dmem_ready), 32'(exp_rdy));
        check($sformatf("%s/c%0d/idx", t.name, c), 32'(load_rs_dmem_idx_executing),
              exp_rdy ? 32'(t.idx) : 32'd0);
        check($sformatf("%s/c%0d/rdata", t.name, c), dmem_rdata, exp_rdy ? t.rdata : 32'd0);
        check($sformatf("%s/c%0d/pop", t.name, c), 32'(store_buffer_pop), 32'd0);
      end else begin
        check($sformatf("%s/c%0d/addr", t.name, c), dcache_addr, t.saddr & ~32'h3);
        check($sformatf("%s/c%0d/wmask", t.name, c), 32'(dcache_wmask), 32'(t.wmask));
        check($sformatf("%s/c%0d/wdata", t.name, c), dcache_wdata, t.wdata);
        check($sformatf("%s/c%0d/rmask", t.name, c), 32'(dcache_rmask), 32'd0);
        check($sformatf("%s/c%0d/pop", t.name, c), 32'(store_buffer_pop), 32'(c == t.lat));
        check($sformatf("%s/c%0d/ready", t.name, c), 32'(load_rs_dmem_ready), 32'd0);
      end
      if (fl) flushed = 1'b1;
    end

    @(negedge clk);
    move_flush = 1'b0; dcache_resp = 1'b0;
    #1;
    check($sformatf("%s/after_rmask", t.name), 32'(dcache_rmask), 32'd0);
    check($sformatf("%s/after_wmask", t.name), 32'(dcache_wmask), 32'd0);
    check($sformatf("%s/after_ready", t.name), 32'(load_rs_dmem_ready), 32'd0);
    check($sformatf("%s/after_pop", t.name), 32'(store_buffer_pop), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "/addr"},  dcache_addr, 32'd0);
    check({name, "/rmask"}, 32'(dcache_rmask), 32'd0);
    check({name, "/wmask"}, 32'(dcache_wmask), 32'd0);
    check({name, "/wdata"}, dcache_wdata, 32'd0);
    check({name, "/ready"}, 32'(load_rs_dmem_ready), 32'd0);
    check({name, "/idx"},   32'(load_rs_dmem_idx_executing), 32'd0);
    check({name, "/rdata"}, dmem_rdata, 32'd0);
    check({name, "/pop"},   32'(store_buffer_pop), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks made", n_checks);
    $fatal(1);
  end

  initial begin
    txn_t tbl[$];
    txn_t t;
    int   seen;
    int   g;
    int   stores;

    idle_inputs();
    rst_n = 1'b0;
    #1;
    dcache_resp = 1'b1;  // a stray response during reset must not leak out
    #1;
    check_all_zero("reset");
    dcache_resp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed transaction table.
    tbl.push_back(mk("load_only",       1,0,0,0, 3'd5, 32'h0000_1003, 4'h8, 32'h0, 4'h0, 32'h0,
                     32'hAABB_CCDD, 3, -1, G_LOAD));
    tbl.push_back(mk("collide_notfull", 1,1,0,0, 3'd2, 32'h0000_2006, 4'hC, 32'h0000_3001, 4'h3,
                     32'h1111_2222, 32'h3333_4444, 2, -1, G_LOAD));
    tbl.push_back(mk("collide_full",    1,1,1,0, 3'd1, 32'h0000_2004, 4'hF, 32'h0000_300B, 4'h6,
                     32'hCAFE_F00D, 32'h5555_6666, 2, -1, G_STORE));
    tbl.push_back(mk("store_only",      0,1,0,0, 3'd0, 32'h0, 4'h0, 32'hFFFF_FFFF, 4'h1,
                     32'h0BAD_BEEF, 32'h0, 1, -1, G_STORE));
    tbl.push_back(mk("load_flush_idle", 1,0,0,1, 3'd3, 32'h0000_4000, 4'h1, 32'h0, 4'h0, 32'h0,
                     32'h7777_8888, 2, -1, G_NONE));
    tbl.push_back(mk("both_flush_idle", 1,1,0,1, 3'd3, 32'h0000_4000, 4'h1, 32'h0000_5000, 4'h2,
                     32'h0, 32'h0, 2, -1, G_NONE));
    tbl.push_back(mk("store_flush_idle",0,1,0,1, 3'd0, 32'h0, 4'h0, 32'h0000_6002, 4'h4,
                     32'h1234_5678, 32'h0, 2, -1, G_STORE));
    tbl.push_back(mk("load_drain",      1,0,0,0, 3'd6, 32'h0000_7001, 4'h2, 32'h0, 4'h0, 32'h0,
                     32'hDEAD_BEEF, 4, 2, G_LOAD));
    tbl.push_back(mk("flush_with_resp", 1,0,0,0, 3'd7, 32'h0000_8003, 4'h8, 32'h0, 4'h0, 32'h0,
                     32'h9999_AAAA, 2, 2, G_LOAD));
    tbl.push_back(mk("store_flush_wait",0,1,0,0, 3'd0, 32'h0, 4'h0, 32'h0000_9007, 4'hF,
                     32'h8765_4321, 32'h0, 3, 1, G_STORE));
    tbl.push_back(mk("nothing",         0,0,0,0, 3'd4, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0,
                     32'h0, 1, -1, G_NONE));
    tbl.push_back(mk("load_after_drain",1,0,0,0, 3'd4, 32'h0000_A00E, 4'h3, 32'h0, 4'h0, 32'h0,
                     32'h0F0F_0F0F, 1, -1, G_LOAD));

    foreach (tbl[i]) do_txn(tbl[i], tbl[i].exp_grant, seen);

    // Reset asserted while a load is waiting on the cache.
    @(negedge clk);
    dmem_r_rqst = 1'b1; load_rs_dmem_idx_rqst = 3'd5;
    arbiter_load_rs_addr = 32'h0000_B00D; arbiter_load_rs_rmask = 4'h4;
    @(negedge clk);
    dmem_r_rqst = 1'b0;
    #1;
    check("rst_mid/rmask_before", 32'(dcache_rmask), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    dcache_resp = 1'b1;
    dcache_rdata = 32'h1357_9BDF;
    #1;
    check("rst_mid/ready_on_resp", 32'(load_rs_dmem_ready), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    starve = 0;
    do_txn(mk("fresh_after_rst", 1,0,0,0, 3'd2, 32'h0000_C001, 4'h1, 32'h0, 4'h0, 32'h0,
              32'h2468_ACE0, 2, -1, G_LOAD), G_LOAD, seen);

    // Both requests held continuously: starvation behaviour.
    reset_dut();
    stores = 0;
    for (int k = 0; k < 12; k++) begin
      t = mk("starve", 1,1,0,0, 3'(k), 32'h0000_D000 + 32'(k * 4), 4'h1,
             32'h0000_E000 + 32'(k * 4), 4'h2, 32'(k), 32'(k + 100), 1, -1, G_NONE);
      g = model_grant(t);
      do_txn(t, g, seen);
      check($sformatf("starve/k%0d/grant", k), 32'(seen), 32'(g));
      if (seen == G_STORE) begin
        stores++;
        check("starve/store_on_9th", 32'(k), 32'd8);
      end
    end
    check("starve/store_count", 32'(stores), GUARD_EN ? 32'd1 : 32'd0);

    // Randomized transactions against the rule model.
    reset_dut();
    for (int n = 0; n < 200; n++) begin
      t.name    = $sformatf("rand%0d", n);
      t.ld      = 1'($urandom_range(0, 1));
      t.st      = 1'($urandom_range(0, 1));
      t.full    = ($urandom_range(0, 3) == 0);
      t.fl_idle = ($urandom_range(0, 7) == 0);
      t.idx     = 3'($urandom);
      t.laddr   = $urandom;
      t.rmask   = 4'($urandom_range(1, 15));
      t.saddr   = $urandom;
      t.wmask   = 4'($urandom_range(1, 15));
      t.wdata   = $urandom;
      t.rdata   = $urandom;
      t.lat     = $urandom_range(1, 4);
      t.flush_at = ($urandom_range(0, 9) < 3) ? $urandom_range(1, t.lat) : -1;
      g = model_grant(t);
      do_txn(t, g, seen);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
